// File: rtl/alu_pkg.sv
// Shared opcode values and scheduler state encoding for the shared-ALU scheduler.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the datapath clients and the shared-ALU scheduler.
interface alu_rr_scheduler_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU; arithmetic wraps and shift amounts use only b[2:0].
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[2:0];
            OP_SRL:  y = a >> b[2:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters, one job in flight.
//
// state | meaning
// IDLE  | search for a valid requester from rr_ptr, accept and latch its operands
// EXEC  | latched operands drive the alu, result registered into rsp_*
// RESP  | rsp_* held until rsp_ready; no grant in this state
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst_n,
    alu_rr_scheduler_if.slave bus
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_ptr_nxt;
    logic [ID_W-1:0]     probe;
    logic [ID_W-1:0]     grant_id;
    logic                grant_hit;
    logic [NUM_REQ-1:0]  ready_c;
    logic                load_req;
    logic                load_rsp;

    logic [WIDTH-1:0]    in_a [NUM_REQ];
    logic [WIDTH-1:0]    in_b [NUM_REQ];
    logic [2:0]          in_op [NUM_REQ];

    logic [WIDTH-1:0]    lat_a;
    logic [WIDTH-1:0]    lat_b;
    logic [2:0]          lat_op;
    logic [ID_W-1:0]     lat_id;
    logic [WIDTH-1:0]    alu_y;

    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [WIDTH-1:0]    rsp_result_q;
    logic                rsp_zero_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign in_a[i]  = bus.req_a[i*WIDTH +: WIDTH];
        assign in_b[i]  = bus.req_b[i*WIDTH +: WIDTH];
        assign in_op[i] = bus.req_op[i*3 +: 3];
    end

    // Wrap by compare so non-power-of-two NUM_REQ never probes a missing requester.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        probe     = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_hit && bus.req_valid[probe]) begin
                grant_hit = 1'b1;
                grant_id  = probe;
            end
            probe = (probe == LAST_ID) ? '0 : probe + 1'b1;
        end
    end

    assign rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        load_req  = 1'b0;
        load_rsp  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    ready_c[grant_id] = 1'b1;
                    load_req          = 1'b1;
                    state_nxt         = EXEC;
                end
            end
            EXEC: begin
                load_rsp  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            ready_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_op       <= '0;
            lat_id       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_req) begin
                lat_a  <= in_a[grant_id];
                lat_b  <= in_b[grant_id];
                lat_op <= in_op[grant_id];
                lat_id <= grant_id;
                rr_ptr <= rr_ptr_nxt;
            end
            if (load_rsp) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= lat_id;
                rsp_result_q <= alu_y;
                rsp_zero_q   <= (alu_y == '0);
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (lat_a),
        .b  (lat_b),
        .op (lat_op),
        .y  (alu_y)
    );

    assign bus.req_ready  = ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus a randomized run against a cycle-level model.
module tb_alu_rr_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_rr_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    alu_rr_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (a * (1 << (b % 8))) % 256;
            6:       r = a / (1 << (b % 8));
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [31:0] m8;
        logic [11:0] m3;
        m8 = 32'hFF << (i * 8);
        m3 = 12'h7 << (i * 3);
        bus.req_a  = (bus.req_a & ~m8) | (32'(a) << (i * 8));
        bus.req_b  = (bus.req_b & ~m8) | (32'(b) << (i * 8));
        bus.req_op = (bus.req_op & ~m3) | (12'(op) << (i * 3));
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One isolated request; returns what the DUT showed, checks are done by the caller.
    task automatic run_one(input int who, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           output logic [3:0] rdy, output int lat, output logic [1:0] id,
                           output logic [7:0] res, output logic z);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        set_req(who, a, b, op);
        bus.req_valid = 4'(1 << who);
        #1 rdy = bus.req_ready;
        @(negedge clk);
        bus.req_valid = '0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        id  = bus.rsp_id;
        res = bus.rsp_result;
        z   = bus.rsp_zero;
    endtask

    task automatic test_reset;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_result !== 8'h00) begin errors++; $display("FAIL reset_rsp_result: got %h want 00", bus.rsp_result); end
        checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero: got %b want 0", bus.rsp_zero); end
        rst_n         = 1'b1;
        bus.req_valid = '0;
    endtask

    task automatic test_single;
        logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] res; logic z;
        run_one(2, 8'h05, 8'h03, 3'd0, rdy, lat, id, res, z);
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", rdy); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", lat); end
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", id); end
        checks++; if (res !== 8'h08) begin errors++; $display("FAIL single_result: got %h want 08", res); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL single_zero: got %b want 0", z); end
    endtask

    task automatic test_sub_zero_wrap;
        logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] res; logic z;
        run_one(1, 8'h10, 8'h10, 3'd1, rdy, lat, id, res, z);
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL sub_ready: got %b want 0010", rdy); end
        checks++; if (id !== 2'd1) begin errors++; $display("FAIL sub_id: got %0d want 1", id); end
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL sub_result: got %h want 00", res); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b want 1", z); end
        run_one(1, 8'hFF, 8'h01, 3'd0, rdy, lat, id, res, z);
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL wrap_result: got %h want 00", res); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL wrap_zero: got %b want 1", z); end
    endtask

    task automatic test_rr_order;
        int gcyc[$];
        int gid[$];
        int want[5] = '{0, 1, 2, 3, 0};
        int who;
        apply_reset;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 1), 8'(i), 3'd0);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready !== 4'b0000) begin
                checks++; if (!$onehot(bus.req_ready)) begin errors++; $display("FAIL rr_onehot: got %b want one bit", bus.req_ready); end
                who = -1;
                for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready == 4'(1 << k)) who = k;
                gcyc.push_back(c);
                gid.push_back(who);
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        checks++; if (gid.size() < 5) begin errors++; $display("FAIL rr_count: got %0d grants want at least 5", gid.size()); end
        for (int k = 0; k < 5 && k < gid.size(); k++) begin
            checks++; if (gid[k] !== want[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gid[k], want[k]); end
        end
        for (int k = 1; k < gcyc.size(); k++) begin
            checks++; if (gcyc[k] - gcyc[k-1] !== 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want 3", k, gcyc[k] - gcyc[k-1]); end
        end
        drain;
    endtask

    task automatic test_backpressure;
        int n;
        apply_reset;
        @(negedge clk);
        set_req(0, 8'h3C, 8'h0F, 3'd2);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b want 0001", bus.req_ready); end
        @(negedge clk);
        set_req(3, 8'h11, 8'h22, 3'd3);
        bus.req_valid = 4'b1001;
        n = 0;
        while (!bus.rsp_valid && n < 6) begin @(negedge clk); n++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 8'h0C) begin errors++; $display("FAIL bp_result: got %h want 0c", bus.rsp_result); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, bus.rsp_valid); end
            checks++; if (bus.rsp_result !== 8'h0C) begin errors++; $display("FAIL bp_hold_result[%0d]: got %h want 0c", c, bus.rsp_result); end
            checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL bp_hold_id[%0d]: got %0d want 0", c, bus.rsp_id); end
            checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL bp_hold_zero[%0d]: got %b want 0", c, bus.rsp_zero); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", c, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_accept_ready: got %b want 0000", bus.req_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp2_valid: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL bp2_id: got %0d want 3", bus.rsp_id); end
        checks++; if (bus.rsp_result !== 8'h33) begin errors++; $display("FAIL bp2_result: got %h want 33", bus.rsp_result); end
        drain;
    endtask

    task automatic test_shifts;
        logic [3:0] rdy; int lat; logic [1:0] id; logic [7:0] res; logic z;
        logic [7:0] want[3] = '{8'h08, 8'h10, 8'h00};
        logic       wz[3]   = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_one(0, 8'h81, 8'h0B, 3'(5 + k), rdy, lat, id, res, z);
            checks++; if (res !== want[k]) begin errors++; $display("FAIL shift_result op%0d: got %h want %h", 5 + k, res, want[k]); end
            checks++; if (z !== wz[k]) begin errors++; $display("FAIL shift_zero op%0d: got %b want %b", 5 + k, z, wz[k]); end
        end
        drain;
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        set_req(1, 8'h07, 8'h01, 3'd0);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = '0;
        n = 0;
        while (!bus.rsp_valid && n < 6) begin @(negedge clk); n++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", bus.rsp_valid); end
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b want 0000", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 8'h00) begin errors++; $display("FAIL mid_result: got %h want 00", bus.rsp_result); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL mid_id: got %0d want 0", bus.rsp_id); end
        rst_n = 1'b1;
        set_req(3, 8'h40, 8'h02, 3'd6);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL mid_grant3: got %b want 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL mid_rsp_id: got %0d want 3", bus.rsp_id); end
        checks++; if (bus.rsp_result !== 8'h10) begin errors++; $display("FAIL mid_rsp_result: got %h want 10", bus.rsp_result); end
        drain;
    endtask

    task automatic test_reset_ptr;
        apply_reset;
        @(negedge clk);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL ptr_after_reset: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        drain;
    endtask

    // Protocol-level model: free -> grant; one busy cycle; response held until taken.
    task automatic test_random;
        int ptr, g, e_id;
        bit pend, in_exec, e_vld;
        logic [7:0] e_res;
        logic [3:0] e_rdy;
        logic [1:0] ix;
        apply_reset;
        ptr = 0; pend = 0; in_exec = 0; e_id = 0; e_res = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            bus.req_op    = 12'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!pend) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    ix = 2'((ptr + k) % NUM_REQ);
                    if (g < 0 && bus.req_valid[ix]) g = (ptr + k) % NUM_REQ;
                end
            end
            e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            e_vld = pend && !in_exec;
            checks++; if (bus.req_ready !== e_rdy) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, e_rdy); end
            checks++; if (bus.rsp_valid !== e_vld) begin errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.rsp_valid, e_vld); end
            if (e_vld) begin
                checks++; if (bus.rsp_id !== 2'(e_id)) begin errors++; $display("FAIL rand_id c%0d: got %0d want %0d", c, bus.rsp_id, e_id); end
                checks++; if (bus.rsp_result !== e_res) begin errors++; $display("FAIL rand_result c%0d: got %h want %h", c, bus.rsp_result, e_res); end
                checks++; if (bus.rsp_zero !== (e_res == 8'h00)) begin errors++; $display("FAIL rand_zero c%0d: got %b want %b", c, bus.rsp_zero, e_res == 8'h00); end
            end
            if (g >= 0) begin
                pend    = 1; in_exec = 1; e_id = g;
                e_res   = ref_alu(int'(8'(bus.req_a >> (g * 8))), int'(8'(bus.req_b >> (g * 8))),
                                  int'(3'(bus.req_op >> (g * 3))));
                ptr     = (g + 1) % NUM_REQ;
            end else if (pend && in_exec) begin
                in_exec = 0;
            end else if (pend && bus.rsp_ready) begin
                pend = 0;
            end
        end
        drain;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        test_reset;
        test_single;
        test_sub_zero_wrap;
        test_rr_order;
        test_backpressure;
        test_shifts;
        test_reset_mid;
        test_random;
        test_reset_ptr;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
